lsu_dcache_port: RTL

- Load/store unit front end; sits directly upstream of the data cache and drives its CPU-side port.
- Accepts one RV32I load or store per request from the execute stage.
- Converts it to a word-aligned cache access with byte-lane write strobes, holds the request until the cache's data_ready, then returns sign/zero-extended load data to writeback.
- Single-outstanding, blocking; pipeline stalls via req_ready.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_load_extend.sv | 37 +++
 rtl/lsu_dcache_port.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-cache port: RV32I funct3 codes, FSM states,
// and helpers for byte-lane strobes and funct3 legality.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic [3:0] lane_strobe(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    if (store) return funct3 inside {F3_SB, F3_SH, F3_SW};
    return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load lane select and sign/zero extension for RV32I loads.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  result = {24'h0, sel_byte};
      F3_LH:   result = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  result = {16'h0, sel_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_dcache_port.sv
// Blocking single-outstanding LSU front end driving the data-cache CPU port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_dcache_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_din,
  output logic              cache_rd,
  output logic [3:0]        cache_wr,
  input  logic [DATA_W-1:0] cache_q,
  input  logic              cache_data_ready
);

  state_t state, state_next;

  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic        misaligned;
  logic        bad_req;
  logic [31:0] store_data;
  logic [31:0] load_result;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bad_req = !funct3_legal(req_store, req_funct3) || misaligned;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  lsu_load_extend u_extend (
    .funct3 (op_funct3),
    .lane   (op_lane),
    .word   (cache_q),
    .result (load_result)
  );

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == RESP);
    case (state)
      IDLE:    if (req_valid) state_next = bad_req ? RESP : REQ;
      REQ:     if (cache_data_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cache port and response fields are registered so they stay stable for the whole wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_store   <= 1'b0;
      op_funct3  <= 3'b000;
      op_lane    <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cache_addr <= '0;
      cache_din  <= '0;
      cache_rd   <= 1'b0;
      cache_wr   <= 4'b0000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_store  <= req_store;
            op_funct3 <= req_funct3;
            op_lane   <= req_addr[1:0];
            if (bad_req) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              cache_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              cache_rd   <= !req_store;
              cache_wr   <= req_store ? lane_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
              cache_din  <= req_store ? store_data : '0;
            end
          end
        end
        REQ: begin
          if (cache_data_ready) begin
            cache_rd   <= 1'b0;
            cache_wr   <= 4'b0000;
            resp_rdata <= op_store ? '0 : load_result;
          end
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
